// File: rtl/hsem_irq_svc.sv
// Semaphore interrupt service engine: reads the interrupt and error status, queues one
// event per set bit into a small FIFO, then clears exactly the bits that were captured.
module hsem_irq_svc #(
  parameter  int INTR_W    = 32,
  parameter  int ERR_W     = 32,
  parameter  int EVT_DEPTH = 4,
  localparam int MAX_W     = (INTR_W > ERR_W) ? INTR_W : ERR_W,
  localparam int IDX_W     = $clog2(MAX_W)
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              intr,
  output logic              int_reg_en,
  input  logic [INTR_W-1:0] intr_stat,
  output logic              err_reg_en,
  input  logic [ERR_W-1:0]  error_stat,
  output logic              int_clr_reg_en,
  output logic [INTR_W-1:0] int_clr_mask,
  output logic              err_clr_reg_en,
  output logic [ERR_W-1:0]  err_clr_mask,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic              evt_src,
  output logic [IDX_W-1:0]  evt_idx,
  output logic              busy
);

  localparam int PTR_W = $clog2(EVT_DEPTH);

  typedef enum logic [2:0] {IDLE, RD_INT, RD_ERR, SCAN, CLR} state_t;

  state_t            state, state_nxt;
  logic [INTR_W-1:0] i_snap, i_work, i_low;
  logic [ERR_W-1:0]  e_snap, e_work, e_low;
  logic [IDX_W-1:0]  i_idx, e_idx;
  logic [IDX_W:0]    push_ent, head_ent;
  logic [IDX_W:0]    fifo_mem [EVT_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [PTR_W:0]    count;
  logic              work_busy, push, pop;

  assign work_busy = (i_work != '0) || (e_work != '0);

  always_ff @(posedge hclk) begin
    if (hreset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (intr) state_nxt = RD_INT;
      RD_INT:  state_nxt = RD_ERR;
      RD_ERR:  state_nxt = SCAN;
      SCAN:    if (!work_busy) state_nxt = CLR;
      CLR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Clear masks come from the snapshots so bits arriving after capture survive.
  always_comb begin
    int_reg_en     = 1'b0;
    err_reg_en     = 1'b0;
    int_clr_reg_en = 1'b0;
    err_clr_reg_en = 1'b0;
    int_clr_mask   = '0;
    err_clr_mask   = '0;
    busy           = (state != IDLE);
    case (state)
      RD_INT: int_reg_en = 1'b1;
      RD_ERR: err_reg_en = 1'b1;
      CLR: begin
        int_clr_reg_en = 1'b1;
        err_clr_reg_en = 1'b1;
        int_clr_mask   = i_snap;
        err_clr_mask   = e_snap;
      end
      default: ;
    endcase
  end

  always_comb begin
    i_idx = '0;
    e_idx = '0;
    for (int k = INTR_W - 1; k >= 0; k--) if (i_work[k]) i_idx = IDX_W'(k);
    for (int k = ERR_W - 1; k >= 0; k--)  if (e_work[k]) e_idx = IDX_W'(k);
  end

  assign i_low    = i_work & (~i_work + INTR_W'(1));
  assign e_low    = e_work & (~e_work + ERR_W'(1));
  assign push_ent = (i_work != '0) ? {1'b0, i_idx} : {1'b1, e_idx};
  assign pop      = evt_valid && evt_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push     = (state == SCAN) && work_busy &&
                    ((count < (PTR_W + 1)'(EVT_DEPTH)) || pop);

  always_ff @(posedge hclk) begin
    if (hreset) begin
      i_snap <= '0;
      i_work <= '0;
      e_snap <= '0;
      e_work <= '0;
    end else begin
      case (state)
        RD_INT: begin
          i_snap <= intr_stat;
          i_work <= intr_stat;
        end
        RD_ERR: begin
          e_snap <= error_stat;
          e_work <= error_stat;
        end
        SCAN: begin
          if (push) begin
            if (i_work != '0) i_work <= i_work & ~i_low;
            else              e_work <= e_work & ~e_low;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge hclk) begin
    if (push) fifo_mem[wr_ptr] <= push_ent;
  end

  assign head_ent  = fifo_mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_src   = evt_valid & head_ent[IDX_W];
  assign evt_idx   = evt_valid ? head_ent[IDX_W-1:0] : '0;

endmodule

// File: tb/tb_hsem_irq_svc.sv
// Directed bench for hsem_irq_svc: a status-register model that honours the clear strobes,
// a vector table of service passes, and hand sequences for reset, backpressure and spurious cases.
module tb_hsem_irq_svc;

  typedef struct {
    logic [31:0] istat;
    logic [31:0] estat;
    int          n_ev;
    logic [35:0] evs;
    logic [31:0] imask;
    logic [31:0] emask;
  } vec_t;

  logic        hclk = 1'b0;
  logic        hreset, intr, int_reg_en, err_reg_en, int_clr_reg_en, err_clr_reg_en;
  logic [31:0] intr_stat, error_stat, int_clr_mask, err_clr_mask;
  logic        evt_valid, evt_ready, evt_src, busy;
  logic [4:0]  evt_idx;

  logic [31:0] stat_int, stat_err, last_imask, last_emask, mask_or;
  logic        spur;
  logic [5:0]  got_q [$];
  int          clr_cnt, both_cnt, valid_cnt, n_pass, n_total;
  vec_t        vecs [6];

  always #5 hclk = ~hclk;

  // Status is only guaranteed while its read select is high; garbage otherwise.
  assign intr       = spur | (|stat_int) | (|stat_err);
  assign intr_stat  = int_reg_en ? stat_int : 32'hDEAD_BEEF;
  assign error_stat = err_reg_en ? stat_err : 32'hBAAD_F00D;

  hsem_irq_svc dut (
    .hclk(hclk), .hreset(hreset), .intr(intr),
    .int_reg_en(int_reg_en), .intr_stat(intr_stat),
    .err_reg_en(err_reg_en), .error_stat(error_stat),
    .int_clr_reg_en(int_clr_reg_en), .int_clr_mask(int_clr_mask),
    .err_clr_reg_en(err_clr_reg_en), .err_clr_mask(err_clr_mask),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_src(evt_src), .evt_idx(evt_idx),
    .busy(busy)
  );

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic reset_counters();
    got_q.delete();
    clr_cnt    = 0;
    both_cnt   = 0;
    valid_cnt  = 0;
    mask_or    = '0;
    last_imask = '1;
    last_emask = '1;
  endtask

  // Record handshakes and clear strobes at the falling edge, then step past the rising edge.
  task automatic apply_stimulus();
    @(negedge hclk);
    if (evt_valid === 1'b1) valid_cnt++;
    if (evt_valid === 1'b1 && evt_ready) got_q.push_back({evt_src, evt_idx});
    if (int_clr_reg_en === 1'b1 || err_clr_reg_en === 1'b1) begin
      clr_cnt++;
      if (int_clr_reg_en && err_clr_reg_en) both_cnt++;
      last_imask = int_clr_mask;
      last_emask = err_clr_mask;
      mask_or    = mask_or | int_clr_mask | err_clr_mask;
      if (int_clr_reg_en) stat_int = stat_int & ~int_clr_mask;
      if (err_clr_reg_en) stat_err = stat_err & ~err_clr_mask;
    end
    @(posedge hclk);
    #1;
  endtask

  task automatic run_pass(input string name, input int target, input int budget);
    int n = 0;
    while (clr_cnt < target && n < budget) begin
      apply_stimulus();
      n++;
    end
    check_output(name, 64'(clr_cnt), 64'(target));
    repeat (3) apply_stimulus();
  endtask

  function automatic logic [7:0] got_at(input int j);
    return (j < got_q.size()) ? {2'b00, got_q[j]} : 8'hFF;
  endfunction

  initial begin
    n_pass    = 0;
    n_total   = 0;
    hreset    = 1'b1;
    spur      = 1'b0;
    stat_int  = 32'h1;
    stat_err  = 32'h0;
    evt_ready = 1'b1;
    reset_counters();

    vecs[0] = '{32'h0000_0005, 32'h0000_0000, 2, {6'h00, 6'h02, 24'h0}, 32'h0000_0005, 32'h0000_0000};
    vecs[1] = '{32'h0000_0001, 32'h8000_0000, 2, {6'h00, 6'h3F, 24'h0}, 32'h0000_0001, 32'h8000_0000};
    vecs[2] = '{32'h8000_0000, 32'h0000_0003, 3, {6'h1F, 6'h20, 6'h21, 18'h0}, 32'h8000_0000, 32'h0000_0003};
    vecs[3] = '{32'h0000_0000, 32'h0000_0010, 1, {6'h24, 30'h0}, 32'h0000_0000, 32'h0000_0010};
    vecs[4] = '{32'h0000_0A00, 32'h0000_0100, 3, {6'h09, 6'h0B, 6'h28, 18'h0}, 32'h0000_0A00, 32'h0000_0100};
    vecs[5] = '{32'h0000_00F0, 32'h0000_0001, 5, {6'h04, 6'h05, 6'h06, 6'h07, 6'h20, 6'h00}, 32'h0000_00F0, 32'h0000_0001};

    // Reset with intr high, then first-pass latency.
    apply_stimulus();
    apply_stimulus();
    check_output("rst_ctrl", {int_reg_en, err_reg_en, int_clr_reg_en, err_clr_reg_en,
                              evt_valid, evt_src, evt_idx, busy}, 64'h0);
    check_output("rst_masks", {int_clr_mask, err_clr_mask}, 64'h0);
    hreset = 1'b0;
    apply_stimulus();
    check_output("rst_rd_int_1cyc", {int_reg_en, err_reg_en}, 64'h2);
    apply_stimulus();
    check_output("lat_err_en_c2", {int_reg_en, err_reg_en}, 64'h1);
    apply_stimulus();
    check_output("lat_no_valid_c3", 64'(evt_valid), 64'h0);
    apply_stimulus();
    check_output("lat_valid_c4", {evt_valid, evt_src, evt_idx}, {58'h0, 1'b1, 6'h00});
    run_pass("rst_pass_done", 1, 40);
    check_output("rst_pass_nevt", 64'(got_q.size()), 64'h1);
    check_output("rst_pass_imask", 64'(last_imask), 64'h1);

    for (int i = 0; i < 6; i++) begin
      reset_counters();
      stat_int = vecs[i].istat;
      stat_err = vecs[i].estat;
      run_pass($sformatf("vec%0d_done", i), 1, 60);
      check_output($sformatf("vec%0d_nevt", i), 64'(got_q.size()), 64'(vecs[i].n_ev));
      for (int j = 0; j < vecs[i].n_ev; j++)
        check_output($sformatf("vec%0d_ev%0d", i, j), 64'(got_at(j)),
                     64'({2'b00, vecs[i].evs[(5 - j) * 6 +: 6]}));
      check_output($sformatf("vec%0d_masks", i), {last_imask, last_emask},
                   {vecs[i].imask, vecs[i].emask});
      check_output($sformatf("vec%0d_both_strobes", i), 64'(both_cnt), 64'h1);
    end

    // A bit raised after capture waits for the following pass.
    reset_counters();
    stat_int = 32'h1;
    apply_stimulus();
    apply_stimulus();
    stat_int = stat_int | 32'h4;
    run_pass("late_pass1_done", 1, 40);
    check_output("late_pass1_mask", 64'(last_imask), 64'h1);
    run_pass("late_pass2_done", 2, 40);
    check_output("late_pass2_mask", 64'(last_imask), 64'h4);
    check_output("late_events", {got_at(0), got_at(1)}, 64'h0002);

    // Backpressure: FIFO fills and SCAN stalls without clearing.
    reset_counters();
    evt_ready = 1'b0;
    stat_int  = 32'h3F;
    repeat (12) apply_stimulus();
    check_output("bp_stall", {evt_valid, busy, evt_src, evt_idx}, {57'h0, 2'b11, 6'h00});
    check_output("bp_no_clr", 64'(clr_cnt), 64'h0);
    evt_ready = 1'b1;
    run_pass("bp_done", 1, 40);
    check_output("bp_nevt", 64'(got_q.size()), 64'h6);
    for (int j = 0; j < 6; j++) check_output($sformatf("bp_ev%0d", j), 64'(got_at(j)), 64'(j));
    check_output("bp_masks", {last_imask, last_emask}, {32'h3F, 32'h0});

    // Reset mid-SCAN after two pushes.
    reset_counters();
    evt_ready = 1'b0;
    stat_int  = 32'h3F;
    repeat (5) apply_stimulus();
    check_output("mid_scan_busy", {evt_valid, busy}, 64'h3);
    hreset = 1'b1;
    apply_stimulus();
    check_output("mid_rst_cleared", {evt_valid, busy}, 64'h0);
    hreset = 1'b0;
    check_output("mid_rst_no_clr", 64'(clr_cnt), 64'h0);
    evt_ready = 1'b1;
    run_pass("mid_rst_repass", 1, 60);
    check_output("mid_rst_nevt", 64'(got_q.size()), 64'h6);
    check_output("mid_rst_mask", 64'(last_imask), 64'h3F);

    // Spurious interrupt: both status registers zero, intr held high.
    reset_counters();
    stat_int = 32'h0;
    stat_err = 32'h0;
    spur     = 1'b1;
    repeat (20) apply_stimulus();
    spur = 1'b0;
    repeat (6) apply_stimulus();
    check_output("spur_no_valid", 64'(valid_cnt), 64'h0);
    check_output("spur_repeats", 64'(clr_cnt >= 3), 64'h1);
    check_output("spur_both", 64'(both_cnt), 64'(clr_cnt));
    check_output("spur_zero_masks", 64'(mask_or), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
